store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered stores (power of two, >=2).
REQ-002 Parameter ADDR_W, default 64, byte-address width.
REQ-003 Parameter DATA_W, default 64, store data width (doubleword).
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 st_valid  input  1  core presents a doubleword store this cycle.
REQ-007 st_addr  input  ADDR_W  store byte address.
REQ-008 st_data  input  DATA_W  store data, little-endian byte order.
REQ-009 st_ready  output  1  buffer accepts the store this cycle.
REQ-010 ld_valid  input  1  core performs a load lookup this cycle.
REQ-011 ld_addr  input  ADDR_W  load byte address.
REQ-012 fwd_hit  output  1  load fully satisfied from buffer.
REQ-013 fwd_data  output  DATA_W  forwarded doubleword, valid when fwd_hit=1.
REQ-014 ld_stall  output  1  load partially overlaps a buffered store and must wait.
REQ-015 mem_free  input  1  data memory port idle this cycle (no load using it).
REQ-016 mem_write  output  1  write strobe to data memory.
REQ-017 mem_addr  output  ADDR_W  head entry address to data memory.
REQ-018 mem_wdata  output  DATA_W  head entry data to data memory.
REQ-019 empty  output  1  no valid entries (fence/drain complete indicator).

Function
REQ-020 Buffer SHALL be a circular FIFO of DEPTH entries {addr, data} with head/tail pointers wrapping modulo DEPTH and a count 0..DEPTH.
REQ-021 st_ready SHALL be 1 iff reset is high and count<DEPTH; a full buffer SHALL deassert st_ready even if the head drains that cycle.
REQ-022 Push on st_valid&&st_ready: entry written at tail, tail+1, entry visible from next cycle.
REQ-023 mem_write SHALL be combinational: 1 iff count>0 and mem_free=1; mem_addr/mem_wdata SHALL always show the head entry (0 when empty).
REQ-024 Pop on mem_write: head+1 at the rising edge; one entry drained per cycle maximum.
REQ-025 A store pushed into an empty buffer SHALL NOT drain in the same cycle (minimum one-cycle residency).
REQ-026 Simultaneous push and pop SHALL leave count unchanged.
REQ-027 Load lookup SHALL be combinational over all valid entries, including the head being drained this cycle; a store pushed in the same cycle SHALL NOT be visible.
REQ-028 Exact match (entry.addr == ld_addr): fwd_hit=1, fwd_data = data of the youngest matching entry.
REQ-029 Partial overlap (entry.addr != ld_addr and |entry.addr - ld_addr| < 8, modulo 2^ADDR_W) on any valid entry: ld_stall=1, fwd_hit=0, regardless of exact matches in other entries.
REQ-030 No match: fwd_hit=0, ld_stall=0, fwd_data=0; with ld_valid=0 both flags SHALL be 0.
REQ-031 empty SHALL equal (count==0).

Reset
REQ-032 While reset=0 at a rising edge: count=0, head=tail=0, all entries invalid, no push or pop occurs.
REQ-033 Outputs during/after reset: st_ready=0 while reset=0, then 1; mem_write=0, fwd_hit=0, ld_stall=0, empty=1, mem_addr=mem_wdata=fwd_data=0.
REQ-034 Reset mid-operation SHALL discard all buffered stores without issuing writes.

Verification
REQ-035 Reset then push addr 0x10 data 0xAA, mem_free=0 -> next cycle empty=0, mem_write=0; set mem_free=1 -> mem_write=1, mem_addr=0x10, mem_wdata=0xAA, empty=1 next cycle.
REQ-036 mem_free=0, push 4 stores (0x00,0x08,0x10,0x18) -> st_ready=0 after fourth; push+drain in same full cycle -> store not accepted, count 3 after edge.
REQ-037 Push 0x20/0x11 then 0x20/0x22, load 0x20 -> fwd_hit=1, fwd_data=0x22, ld_stall=0.
REQ-038 Buffered 0x20, load 0x24 -> ld_stall=1, fwd_hit=0; load 0x28 -> both 0.
REQ-039 Push 0x30 and load 0x30 in same cycle on empty buffer -> fwd_hit=0; following cycle -> fwd_hit=1.
REQ-040 Three entries buffered, reset=0 one cycle with mem_free=1 -> mem_write=0 during reset, empty=1 after, no writes issued.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of doubleword stores that drains to data memory
// on idle memory cycles and forwards exact-match data to loads.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              ld_stall,
  input  logic              mem_free,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic              has_data;
  logic              push;
  logic              pop;

  // Handshake: a store is accepted when st_valid && st_ready at the rising
  // edge; st_ready depends only on reset and occupancy, never on a same-cycle drain.
  assign has_data  = (count != '0);
  assign st_ready  = reset && (count < CNT_W'(DEPTH));
  assign push      = st_valid && st_ready;
  assign mem_write = reset && has_data && mem_free;
  assign pop       = mem_write;
  assign mem_addr  = (reset && has_data) ? addr_q[head] : '0;
  assign mem_wdata = (reset && has_data) ? data_q[head] : '0;
  assign empty     = !reset || !has_data;

  // Per-age view of the buffer: age 0 is the head (oldest), higher ages are younger.
  logic [PTR_W-1:0]  age_idx   [DEPTH];
  logic [DEPTH-1:0]  age_valid;
  logic [DEPTH-1:0]  age_exact;
  logic [DEPTH-1:0]  age_near;
  logic [ADDR_W-1:0] diff_up   [DEPTH];
  logic [ADDR_W-1:0] diff_dn   [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    assign age_idx[k]   = head + PTR_W'(k);
    assign age_valid[k] = (CNT_W'(k) < count);
    assign diff_up[k]   = addr_q[age_idx[k]] - ld_addr;
    assign diff_dn[k]   = ld_addr - addr_q[age_idx[k]];
    assign age_exact[k] = (diff_up[k] == '0);
    // Modular distance below one doubleword means the byte ranges overlap.
    assign age_near[k]  = !age_exact[k] &&
                          ((diff_up[k] < ADDR_W'(8)) || (diff_dn[k] < ADDR_W'(8)));
  end

  logic              any_hit;
  logic              any_near;
  logic [DATA_W-1:0] hit_data;

  always_comb begin
    any_hit  = 1'b0;
    any_near = 1'b0;
    hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (age_valid[k]) begin
        if (age_exact[k]) begin
          any_hit  = 1'b1;
          hit_data = data_q[age_idx[k]];
        end
        if (age_near[k]) begin
          any_near = 1'b1;
        end
      end
    end
  end

  assign ld_stall = reset && ld_valid && any_near;
  assign fwd_hit  = reset && ld_valid && any_hit && !any_near;
  assign fwd_data = fwd_hit ? hit_data : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: validity comes from head/count.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      addr_q[tail] <= st_addr;
      data_q[tail] <= st_data;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: driver pushes expected output vectors,
// a negedge monitor pops and compares them against the DUT.
module tb_store_buffer;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int EW = 5 + AW + DW + DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          ld_stall;
  logic          mem_free;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          empty;

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];
  string         name_q[$];

  // clock / reset
  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .ld_stall(ld_stall),
    .mem_free(mem_free), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .empty(empty)
  );

  // driver: apply one cycle of inputs and queue the outputs expected that cycle
  task automatic cyc(input logic rst, input logic sv, input logic [AW-1:0] sa,
                     input logic [DW-1:0] sd, input logic lv, input logic [AW-1:0] la,
                     input logic mf, input logic e_sr, input logic e_mw,
                     input logic e_hit, input logic e_stall, input logic e_empty,
                     input logic [AW-1:0] e_ma, input logic [DW-1:0] e_md,
                     input logic [DW-1:0] e_fd, input string nm);
    @(posedge clk);
    #1;
    reset    = rst;
    st_valid = sv;
    st_addr  = sa;
    st_data  = sd;
    ld_valid = lv;
    ld_addr  = la;
    mem_free = mf;
    exp_q.push_back({e_sr, e_mw, e_hit, e_stall, e_empty, e_ma, e_md, e_fd});
    name_q.push_back(nm);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] act;
      logic [EW-1:0] exp_v;
      string nm;
      act   = {st_ready, mem_write, fwd_hit, ld_stall, empty, mem_addr, mem_wdata, fwd_data};
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL %s: got {sr,mw,hit,stall,empty}=%b ma=%h md=%h fd=%h, expected %b ma=%h md=%h fd=%h",
                 nm, act[EW-1:EW-5], act[AW+2*DW-1:2*DW], act[2*DW-1:DW], act[DW-1:0],
                 exp_v[EW-1:EW-5], exp_v[AW+2*DW-1:2*DW], exp_v[2*DW-1:DW], exp_v[DW-1:0]);
      end
    end
  end

  initial begin
    reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0; mem_free = 1'b0;
    repeat (2) @(posedge clk);

    //  rst sv addr   data    lv addr   mf  sr mw hit stl emp  ma     md     fd
    cyc(0, 0, 64'h0,  64'h0,  0, 64'h0,  0,  0, 0, 0, 0, 1,  64'h0,  64'h0,  64'h0,  "reset_idle");
    // single store, held then drained
    cyc(1, 1, 64'h10, 64'hAA, 0, 64'h0,  0,  1, 0, 0, 0, 1,  64'h0,  64'h0,  64'h0,  "push_into_empty");
    cyc(1, 0, 64'h0,  64'h0,  0, 64'h0,  0,  1, 0, 0, 0, 0,  64'h10, 64'hAA, 64'h0,  "held_mem_busy");
    cyc(1, 0, 64'h0,  64'h0,  0, 64'h0,  1,  1, 1, 0, 0, 0,  64'h10, 64'hAA, 64'h0,  "drain_one");
    cyc(1, 0, 64'h0,  64'h0,  0, 64'h0,  0,  1, 0, 0, 0, 1,  64'h0,  64'h0,  64'h0,  "empty_after_drain");
    // fill to full, then push+drain while full
    cyc(1, 1, 64'h00, 64'h100, 0, 64'h0, 0,  1, 0, 0, 0, 1,  64'h0,  64'h0,  64'h0,  "fill_0");
    cyc(1, 1, 64'h08, 64'h108, 0, 64'h0, 0,  1, 0, 0, 0, 0,  64'h00, 64'h100, 64'h0, "fill_1");
    cyc(1, 1, 64'h10, 64'h110, 0, 64'h0, 0,  1, 0, 0, 0, 0,  64'h00, 64'h100, 64'h0, "fill_2");
    cyc(1, 1, 64'h18, 64'h118, 0, 64'h0, 0,  1, 0, 0, 0, 0,  64'h00, 64'h100, 64'h0, "fill_3");
    cyc(1, 1, 64'h20, 64'h120, 0, 64'h0, 1,  0, 1, 0, 0, 0,  64'h00, 64'h100, 64'h0, "full_push_drain");
    cyc(1, 0, 64'h0,  64'h0,  1, 64'h18, 0,  1, 0, 1, 0, 0,  64'h08, 64'h108, 64'h118, "count3_fwd_18");
    cyc(1, 0, 64'h0,  64'h0,  1, 64'h20, 0,  1, 0, 0, 0, 0,  64'h08, 64'h108, 64'h0, "rejected_store_absent");
    cyc(1, 0, 64'h0,  64'h0,  0, 64'h0,  1,  1, 1, 0, 0, 0,  64'h08, 64'h108, 64'h0, "drain_08");
    cyc(1, 0, 64'h0,  64'h0,  0, 64'h0,  1,  1, 1, 0, 0, 0,  64'h10, 64'h110, 64'h0, "drain_10");
    cyc(1, 0, 64'h0,  64'h0,  0, 64'h0,  1,  1, 1, 0, 0, 0,  64'h18, 64'h118, 64'h0, "drain_18");
    cyc(1, 0, 64'h0,  64'h0,  0, 64'h0,  1,  1, 0, 0, 0, 1,  64'h0,  64'h0,  64'h0,  "empty_no_write");
    // youngest-match forwarding and partial overlaps
    cyc(1, 1, 64'h20, 64'h11, 0, 64'h0,  0,  1, 0, 0, 0, 1,  64'h0,  64'h0,  64'h0,  "push_20_11");
    cyc(1, 1, 64'h20, 64'h22, 0, 64'h0,  0,  1, 0, 0, 0, 0,  64'h20, 64'h11, 64'h0,  "push_20_22");
    cyc(1, 0, 64'h0,  64'h0,  1, 64'h20, 0,  1, 0, 1, 0, 0,  64'h20, 64'h11, 64'h22, "fwd_youngest");
    cyc(1, 0, 64'h0,  64'h0,  1, 64'h24, 0,  1, 0, 0, 1, 0,  64'h20, 64'h11, 64'h0,  "stall_24");
    cyc(1, 0, 64'h0,  64'h0,  1, 64'h28, 0,  1, 0, 0, 0, 0,  64'h20, 64'h11, 64'h0,  "nomatch_28");
    cyc(1, 0, 64'h0,  64'h0,  1, 64'h19, 0,  1, 0, 0, 1, 0,  64'h20, 64'h11, 64'h0,  "stall_19_below");
    cyc(1, 0, 64'h0,  64'h0,  1, 64'h18, 0,  1, 0, 0, 0, 0,  64'h20, 64'h11, 64'h0,  "nomatch_18");
    cyc(1, 0, 64'h0,  64'h0,  0, 64'h20, 1,  1, 1, 0, 0, 0,  64'h20, 64'h11, 64'h0,  "ld_valid_low");
    cyc(1, 0, 64'h0,  64'h0,  1, 64'h20, 1,  1, 1, 1, 0, 0,  64'h20, 64'h22, 64'h22, "fwd_from_draining_head");
    cyc(1, 0, 64'h0,  64'h0,  1, 64'h20, 0,  1, 0, 0, 0, 1,  64'h0,  64'h0,  64'h0,  "empty_no_fwd");
    // same-cycle push is invisible; partial overlap beats exact match; wrap distance
    cyc(1, 1, 64'h30, 64'h33, 1, 64'h30, 0,  1, 0, 0, 0, 1,  64'h0,  64'h0,  64'h0,  "same_cycle_invisible");
    cyc(1, 0, 64'h0,  64'h0,  1, 64'h30, 0,  1, 0, 1, 0, 0,  64'h30, 64'h33, 64'h33, "next_cycle_visible");
    cyc(1, 1, 64'h34, 64'h44, 1, 64'h30, 0,  1, 0, 1, 0, 0,  64'h30, 64'h33, 64'h33, "push_34_fwd_30");
    cyc(1, 0, 64'h0,  64'h0,  1, 64'h30, 0,  1, 0, 0, 1, 0,  64'h30, 64'h33, 64'h0,  "stall_overrides_exact");
    cyc(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h55, 0, 64'h0, 0, 1, 0, 0, 0, 0, 64'h30, 64'h33, 64'h0, "push_top");
    cyc(1, 0, 64'h0,  64'h0,  1, 64'h0,  0,  1, 0, 0, 1, 0,  64'h30, 64'h33, 64'h0,  "stall_wraparound");
    // reset with three entries buffered and memory free
    cyc(0, 1, 64'h40, 64'h66, 1, 64'h30, 1,  0, 0, 0, 0, 1,  64'h0,  64'h0,  64'h0,  "reset_mid_op");
    cyc(1, 0, 64'h0,  64'h0,  1, 64'h30, 1,  1, 0, 0, 0, 1,  64'h0,  64'h0,  64'h0,  "after_reset_discarded");
    cyc(1, 0, 64'h0,  64'h0,  1, 64'h40, 1,  1, 0, 0, 0, 1,  64'h0,  64'h0,  64'h0,  "reset_push_dropped");

    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain_queue: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
